// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared widths, Tuse/Tnew encodings, MD latencies and the
//                scoreboard entry type for the hazard scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
package hazard_pkg;

    localparam int HAZ_REG_AW   = 5;
    localparam int HAZ_TW       = 2;
    localparam int HAZ_MULT_LAT = 5;
    localparam int HAZ_DIV_LAT  = 10;

    localparam logic [HAZ_TW-1:0] TUSE_D    = 2'd0;
    localparam logic [HAZ_TW-1:0] TUSE_E    = 2'd1;
    localparam logic [HAZ_TW-1:0] TUSE_M    = 2'd2;
    localparam logic [HAZ_TW-1:0] TNEW_PC8  = 2'd0;
    localparam logic [HAZ_TW-1:0] TNEW_ALU  = 2'd1;
    localparam logic [HAZ_TW-1:0] TNEW_LOAD = 2'd2;

    typedef struct packed {
        logic                  valid;
        logic [HAZ_REG_AW-1:0] waddr;
        logic [HAZ_TW-1:0]     tnew;
    } sb_entry_t;

    // One stage closer to the result being forwardable; never goes below zero.
    function automatic logic [HAZ_TW-1:0] tnew_age(input logic [HAZ_TW-1:0] t);
        return (t == '0) ? t : t - 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_busy_counter.sv
`default_nettype none
// ============================================================================
//  Module      : md_busy_counter
//  Description : Multiply/divide busy counter; load beats decrement, keeps
//                counting regardless of pipeline freeze.
//  Revision    : 1.0  initial release
// ============================================================================
module md_busy_counter
    import hazard_pkg::*;
#(
    parameter int MULT_LAT = HAZ_MULT_LAT,
    parameter int DIV_LAT  = HAZ_DIV_LAT,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_is_div,
    output logic o_busy
);

    logic [CNT_W-1:0] md_cnt_q;
    logic [CNT_W-1:0] md_cnt_d;

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (i_load) begin
            md_cnt_d = i_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    assign o_busy = (md_cnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Tuse/Tnew scoreboard stall unit with MD busy tracking.
//                Optional stall statistics under macro HAZ_PERF_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW   = HAZ_REG_AW,
    parameter int STAGES   = 3,
    parameter int TW       = HAZ_TW,
    parameter int MULT_LAT = HAZ_MULT_LAT,
    parameter int DIV_LAT  = HAZ_DIV_LAT,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] ra1_D,
    input  logic [REG_AW-1:0] ra2_D,
    input  logic              use_rs_D,
    input  logic              use_rt_D,
    input  logic [TW-1:0]     tuse_rs_D,
    input  logic [TW-1:0]     tuse_rt_D,
    input  logic              wen_D,
    input  logic [REG_AW-1:0] waddr_D,
    input  logic [TW-1:0]     tnew_D,
    input  logic              muldiv_D,
    input  logic              md_start_D,
    input  logic              md_is_div_D,
    input  logic              freeze,
    output logic              stall,
    output logic              md_busy
`ifdef HAZ_PERF_EN
    ,
    output logic [31:0]       stall_cnt_data,
    output logic [31:0]       stall_cnt_md
`endif
);

    // Entry widths come from the package; REG_AW/TW must stay at those defaults.
    sb_entry_t sb_q [STAGES];
    sb_entry_t sb_d [STAGES];

    logic          w_rs_hit, w_rt_hit;
    logic [TW-1:0] w_rs_tnew, w_rt_tnew;
    logic          w_rs_haz, w_rt_haz, w_md_haz;
    logic          w_md_load;

    // Scan oldest to youngest so the youngest matching writer wins.
    always_comb begin
        w_rs_hit  = 1'b0;
        w_rs_tnew = '0;
        w_rt_hit  = 1'b0;
        w_rt_tnew = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (sb_q[k].valid && (sb_q[k].waddr == ra1_D)) begin
                w_rs_hit  = 1'b1;
                w_rs_tnew = sb_q[k].tnew;
            end
            if (sb_q[k].valid && (sb_q[k].waddr == ra2_D)) begin
                w_rt_hit  = 1'b1;
                w_rt_tnew = sb_q[k].tnew;
            end
        end
    end

    assign w_rs_haz  = use_rs_D && (ra1_D != '0) && w_rs_hit && (w_rs_tnew > tuse_rs_D);
    assign w_rt_haz  = use_rt_D && (ra2_D != '0) && w_rt_hit && (w_rt_tnew > tuse_rt_D);
    assign w_md_haz  = muldiv_D && md_busy;
    assign stall     = w_rs_haz | w_rt_haz | w_md_haz;
    assign w_md_load = md_start_D && !stall && !freeze;

    always_comb begin
        sb_d = sb_q;
        if (!freeze) begin
            if (stall) begin
                sb_d[0] = '0;
            end else begin
                sb_d[0].valid = wen_D && (waddr_D != '0);
                sb_d[0].waddr = waddr_D;
                sb_d[0].tnew  = tnew_D;
            end
            for (int k = 1; k < STAGES; k++) begin
                sb_d[k]      = sb_q[k-1];
                sb_d[k].tnew = tnew_age(sb_q[k-1].tnew);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                sb_q[k] <= '0;
            end
        end else begin
            sb_q <= sb_d;
        end
    end

    md_busy_counter #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_md_busy_counter (
        .clk      (clk),
        .rst      (reset),
        .i_load   (w_md_load),
        .i_is_div (md_is_div_D),
        .o_busy   (md_busy)
    );

`ifdef HAZ_PERF_EN
    logic [31:0] stall_cnt_data_q, stall_cnt_data_d;
    logic [31:0] stall_cnt_md_q,   stall_cnt_md_d;

    always_comb begin
        stall_cnt_data_d = stall_cnt_data_q;
        stall_cnt_md_d   = stall_cnt_md_q;
        if (!freeze && (w_rs_haz || w_rt_haz)) begin
            stall_cnt_data_d = stall_cnt_data_q + 32'd1;
        end
        if (!freeze && w_md_haz) begin
            stall_cnt_md_d = stall_cnt_md_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_data_q <= '0;
            stall_cnt_md_q   <= '0;
        end else begin
            stall_cnt_data_q <= stall_cnt_data_d;
            stall_cnt_md_q   <= stall_cnt_md_d;
        end
    end

    assign stall_cnt_data = stall_cnt_data_q;
    assign stall_cnt_md   = stall_cnt_md_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_scoreboard
//  Description : Directed self-checking bench for hazard_scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ra1_D, ra2_D, waddr_D;
    logic       use_rs_D, use_rt_D, wen_D;
    logic [1:0] tuse_rs_D, tuse_rt_D, tnew_D;
    logic       muldiv_D, md_start_D, md_is_div_D, freeze;
    logic       stall, md_busy;
`ifdef HAZ_PERF_EN
    logic [31:0] stall_cnt_data, stall_cnt_md;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .ra1_D       (ra1_D),
        .ra2_D       (ra2_D),
        .use_rs_D    (use_rs_D),
        .use_rt_D    (use_rt_D),
        .tuse_rs_D   (tuse_rs_D),
        .tuse_rt_D   (tuse_rt_D),
        .wen_D       (wen_D),
        .waddr_D     (waddr_D),
        .tnew_D      (tnew_D),
        .muldiv_D    (muldiv_D),
        .md_start_D  (md_start_D),
        .md_is_div_D (md_is_div_D),
        .freeze      (freeze),
        .stall       (stall),
        .md_busy     (md_busy)
`ifdef HAZ_PERF_EN
        ,
        .stall_cnt_data (stall_cnt_data),
        .stall_cnt_md   (stall_cnt_md)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        use_rs_D = 0; use_rt_D = 0; ra1_D = 0; ra2_D = 0;
        tuse_rs_D = 0; tuse_rt_D = 0;
        wen_D = 0; waddr_D = 0; tnew_D = 0;
        muldiv_D = 0; md_start_D = 0; md_is_div_D = 0;
    endtask

    task automatic wr(input logic [4:0] rd, input logic [1:0] tn);
        nop();
        wen_D = 1; waddr_D = rd; tnew_D = tn;
    endtask

    task automatic rd_rs(input logic [4:0] rs, input logic [1:0] tu);
        nop();
        use_rs_D = 1; ra1_D = rs; tuse_rs_D = tu;
    endtask

    task automatic drain();
        nop();
        repeat (3) tick();
    endtask

    initial begin
        nop();
        freeze = 0;
        reset  = 1;
        repeat (2) tick();
        reset = 0;
        #1;
        chk("reset_stall", stall, 0);
        chk("reset_busy", md_busy, 0);
`ifdef HAZ_PERF_EN
        chk("reset_cnt_data", stall_cnt_data, 0);
        chk("reset_cnt_md", stall_cnt_md, 0);
`endif

        // load-use: one bubble
        wr(5'd1, 2'd2); #1; chk("lu_lw_nostall", stall, 0); tick();
        rd_rs(5'd1, 2'd1); wen_D = 1; waddr_D = 5'd2; tnew_D = 2'd1;
        #1; chk("lu_stall", stall, 1); tick();
        chk("lu_release", stall, 0); tick();
        drain();

        // branch after ALU: one cycle; after load: two cycles
        wr(5'd4, 2'd1); tick();
        rd_rs(5'd4, 2'd0); #1; chk("br_alu_s1", stall, 1); tick();
        chk("br_alu_rel", stall, 0); tick();
        drain();
        wr(5'd4, 2'd2); tick();
        rd_rs(5'd4, 2'd0); #1; chk("br_lw_s1", stall, 1); tick();
        chk("br_lw_s2", stall, 1); tick();
        chk("br_lw_rel", stall, 0); tick();
        drain();

        // $0 never hazards
        wr(5'd0, 2'd2); tick();
        rd_rs(5'd0, 2'd0); #1; chk("r0_nostall", stall, 0); tick();
        drain();

        // youngest match: lw $5, ori $5, use $5 tuse 1
        wr(5'd5, 2'd2); tick();
        wr(5'd5, 2'd1); #1; chk("ym_ori_nostall", stall, 0); tick();
        rd_rs(5'd5, 2'd1); #1; chk("ym_alu_nostall", stall, 0); tick();
        drain();

        // youngest match: lw $5, jal-style $5 (tnew 0), use $5 tuse 0
        wr(5'd5, 2'd2); tick();
        wr(5'd5, 2'd0); tick();
        rd_rs(5'd5, 2'd0); #1; chk("ym_pc8_nostall", stall, 0); tick();
        drain();

        // rt path
        wr(5'd6, 2'd1); tick();
        nop(); use_rt_D = 1; ra2_D = 5'd6; tuse_rt_D = 2'd0;
        #1; chk("rt_stall", stall, 1); tick();
        chk("rt_release", stall, 0); tick();
        drain();

        // divide then mfhi: 10 stall cycles
        nop(); muldiv_D = 1; md_start_D = 1; md_is_div_D = 1;
        #1; chk("div_start_nostall", stall, 0); tick();
        nop(); muldiv_D = 1; wen_D = 1; waddr_D = 5'd7; tnew_D = 2'd1;
        for (int i = 0; i < 10; i++) begin
            chk("div_busy", md_busy, 1);
            chk("div_stall", stall, 1);
            tick();
        end
        chk("div_done_busy", md_busy, 0);
        chk("div_done_stall", stall, 0);
        tick();
        drain();

        // multiply then mflo: 5 stall cycles
        nop(); muldiv_D = 1; md_start_D = 1;
        #1; chk("mul_start_nostall", stall, 0); tick();
        nop(); muldiv_D = 1;
        for (int i = 0; i < 5; i++) begin
            chk("mul_stall", stall, 1);
            tick();
        end
        chk("mul_done_busy", md_busy, 0);
        chk("mul_done_stall", stall, 0);
        tick();
        drain();

        // freeze holds the scoreboard
        wr(5'd1, 2'd2); tick();
        rd_rs(5'd1, 2'd1); freeze = 1;
        for (int i = 0; i < 3; i++) begin
            #1; chk("frz_stall", stall, 1);
            tick();
        end
        freeze = 0;
        #1; chk("frz_last_stall", stall, 1); tick();
        chk("frz_release", stall, 0); tick();
        drain();

        // reset mid-divide at md_cnt = 6, with a load in E
        nop(); muldiv_D = 1; md_start_D = 1; md_is_div_D = 1; tick();
        nop(); repeat (3) tick();
        wr(5'd1, 2'd2); tick();
        chk("rst_pre_busy", md_busy, 1);
        rd_rs(5'd1, 2'd0); #1; chk("rst_pre_data_stall", stall, 1);
        nop(); muldiv_D = 1; #1; chk("rst_pre_md_stall", stall, 1);
`ifdef HAZ_PERF_EN
        chk("pre_cnt_data", stall_cnt_data, 6);
        chk("pre_cnt_md", stall_cnt_md, 15);
`endif
        reset = 1; tick(); reset = 0;
        #1;
        chk("rst_busy", md_busy, 0);
        chk("rst_md_stall", stall, 0);
        rd_rs(5'd1, 2'd0); #1; chk("rst_sb_clear", stall, 0);
`ifdef HAZ_PERF_EN
        chk("rst_cnt_data", stall_cnt_data, 0);
        chk("rst_cnt_md", stall_cnt_md, 0);
`endif
        nop();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
